stage_operator_writeback: RTL and testbench
===========================================

Name: stage_operator_writeback

Overview:
- Final pipeline stage after the waveform/envelope stages; the writer end of the operator-output writeback interface consumed by stage_modulator.
- Each cycle it takes one finished operator sample, registers it onto the writeback bus (i_OperatorWritebackID / i_OperatorWritebackValue of stage_modulator).
- It also sums every carrier operator of every voice into one mixed audio sample per frame, emitted with a one-cycle valid strobe.

Parameters:
- NUM_VOICE_OPERATORS, 128: voice-operator slots per frame; must be a power of two; equals `NUM_VOICE_OPERATORS.
- ACC_WIDTH, 23: mix accumulator width, 16 + log2(NUM_VOICE_OPERATORS).

Ports:
- i_Clock  in  1  system clock; all state on its rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Valid  in  1  input sample present this cycle.
- i_NoteOn  in  1  note gate for this voice-operator.
- i_VoiceOperator  in  VoiceOperatorID_t  slot ID of the input sample.
- i_AlgorithmWord  in  AlgorithmWord_t  algorithm word carried down the pipeline; the IsCarrier field selects mix contribution.
- i_OperatorOutput  in  signed 16  operator output sample.
- o_WritebackValid  out  1  writeback bus carries a new value.
- o_OperatorWritebackID  out  VoiceOperatorID_t  slot to write in the modulator memory.
- o_OperatorWritebackValue  out  signed 16  value to write.
- o_Sample  out  signed 16  mixed frame sample.
- o_SampleValid  out  1  one-cycle strobe; o_Sample is new.
- o_FrameError  out  1  sticky frame-alignment error flag.

Behaviour:
- Reset (asynchronous, i_Reset_n low): all outputs 0, accumulator 0, expected-ID counter 0. Deassertion takes effect on the next rising edge.
- Effective value: eff = i_NoteOn ? i_OperatorOutput : 0.
- Writeback path, latency 1:
  - Cycle with i_Valid=1 → next cycle o_WritebackValid=1, o_OperatorWritebackID=i_VoiceOperator, o_OperatorWritebackValue=eff.
  - i_Valid=0 → o_WritebackValid=0; ID and value hold their last values. Re-writing the held value is harmless to the consumer.
- Mix contribution: contrib = (i_AlgorithmWord.IsCarrier) ? sign-extend(eff) to ACC_WIDTH : 0.
- Frame order: slots arrive in increasing ID order, 0..NUM_VOICE_OPERATORS-1, then wrap. An internal expected-ID counter advances on each valid input. Gaps of i_Valid=0 are allowed anywhere and do not advance state.
- Normal valid input, ID == expected and ID != last: acc <= acc + contrib; expected <= ID+1.
- Last slot (ID == NUM_VOICE_OPERATORS-1), valid:
  - o_Sample <= fmt(acc + contrib); o_SampleValid <= 1 for exactly that next cycle.
  - acc <= 0; expected <= 0.
- Misalignment, valid with ID != expected:
  - o_FrameError <= 1; it stays set until reset.
  - acc <= contrib as a fresh partial frame; expected <= ID+1 (wrap at last).
  - If that ID is also the last slot, the last-slot rule applies with acc treated as 0.
  - No sample is emitted for the broken frame.
- Accumulator: ACC_WIDTH signed. It cannot overflow, since 128 × ±32768 fits in 23 bits.
- fmt(): defined by the optional feature below.
- o_SampleValid is 0 on every cycle not following a last-slot input.

Optional Feature:
- Macro: STAGE_WRITEBACK_SATURATE_EN.
- Defined: fmt(x) clamps x to [-32768, 32767] and returns 16 bits.
- Undefined: fmt(x) = x[15:0], two's-complement wrap, with no clamp logic.
- The writeback path is identical in both builds.

Test Plan:
- Reset mid-frame: assert i_Reset_n=0 after 5 valid slots, release, run a full frame → all outputs 0 during reset; the next frame's sum excludes pre-reset slots; o_FrameError=0.
- Writeback latency: i_Valid=1, ID=0x25, NoteOn=1, output=-1234 → next cycle o_WritebackValid=1, ID=0x25, value=-1234. Same input with NoteOn=0 → value=0.
- Carrier mix: full frame where only slots 0, 8, 16 are IsCarrier with outputs 1000, 2000, -500; all others output 7777 as non-carriers → single strobe with o_Sample=2500, 1 cycle after slot 127.
- Saturation: 4 carriers at 20000 in one frame → built with STAGE_WRITEBACK_SATURATE_EN, o_Sample=32767; built without it, o_Sample=80000 mod 65536 = 14464.
- Gaps: a full frame with i_Valid=0 bubbles inserted between every slot → same o_Sample as the gapless frame; exactly one strobe per frame.
- Misalignment: slots 0..9, then ID 20 → o_FrameError=1 from the next cycle; no strobe for that frame. Slots 21..127 follow with carrier 100 each, plus ID 20 = 100 → strobe with o_Sample=10800. o_FrameError stays 1.

Source files
------------

// File: rtl/stage_operator_writeback.sv
// Operator writeback stage: registers each finished operator sample onto the
// modulator writeback bus, and mixes all carrier operators of a frame into one
// audio sample with a one-cycle valid strobe.
// Optional build macro STAGE_WRITEBACK_SATURATE_EN: clamp the mixed sample to
// the signed 16-bit range instead of wrapping.
// i_AlgorithmWord is carried as a flat vector; bit IS_CARRIER_BIT is the
// IsCarrier field, and the remaining bits are not used by this stage.
module stage_operator_writeback #(
   parameter int unsigned NUM_VOICE_OPERATORS = 128,
   parameter int unsigned ACC_WIDTH           = 23,
   parameter int unsigned ALG_WIDTH           = 8,
   parameter int unsigned IS_CARRIER_BIT      = 0,
   localparam int unsigned ID_WIDTH           = $clog2(NUM_VOICE_OPERATORS)
) (
   input  logic                       i_Clock,
   input  logic                       i_Reset_n,
   input  logic                       i_Valid,
   input  logic                       i_NoteOn,
   input  logic [ID_WIDTH-1:0]        i_VoiceOperator,
   input  logic [ALG_WIDTH-1:0]       i_AlgorithmWord,
   input  logic signed [15:0]         i_OperatorOutput,
   output logic                       o_WritebackValid,
   output logic [ID_WIDTH-1:0]        o_OperatorWritebackID,
   output logic signed [15:0]         o_OperatorWritebackValue,
   output logic signed [15:0]         o_Sample,
   output logic                       o_SampleValid,
   output logic                       o_FrameError
);

   localparam logic [ID_WIDTH-1:0] LastId = ID_WIDTH'(NUM_VOICE_OPERATORS - 1);

`ifdef STAGE_WRITEBACK_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'(32767);
   localparam logic signed [ACC_WIDTH-1:0] SatMin = ACC_WIDTH'(-32768);
`endif

   logic                        wb_valid_q, wb_valid_d;
   logic [ID_WIDTH-1:0]         wb_id_q, wb_id_d;
   logic signed [15:0]          wb_value_q, wb_value_d;
   logic signed [15:0]          sample_q, sample_d;
   logic                        sample_valid_q, sample_valid_d;
   logic                        frame_error_q, frame_error_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ID_WIDTH-1:0]         expected_q, expected_d;

   logic signed [15:0]          eff;
   logic signed [ACC_WIDTH-1:0] contrib;
   logic signed [ACC_WIDTH-1:0] sum;
   logic signed [15:0]          sum_fmt;
   logic                        aligned;
   logic                        is_last;

   // Non-carrier bits of the algorithm word ride along unused here.
   logic unused_alg;
   assign unused_alg = ^i_AlgorithmWord;

   // Effective value, mix contribution and the running frame sum.
   always_comb begin
      eff     = i_NoteOn ? i_OperatorOutput : 16'sd0;
      contrib = i_AlgorithmWord[IS_CARRIER_BIT] ?
                {{(ACC_WIDTH - 16){eff[15]}}, eff} : '0;
      aligned = (i_VoiceOperator == expected_q);
      is_last = (i_VoiceOperator == LastId);
      // A misaligned slot restarts the frame, so the old partial sum is dropped.
      sum     = (aligned ? acc_q : '0) + contrib;
`ifdef STAGE_WRITEBACK_SATURATE_EN
      if (sum > SatMax) begin
         sum_fmt = 16'sh7fff;
      end else if (sum < SatMin) begin
         sum_fmt = -16'sh8000;
      end else begin
         sum_fmt = sum[15:0];
      end
`else
      sum_fmt = sum[15:0];
`endif
   end

   // Next-state for writeback bus, mixer and frame tracking.
   always_comb begin
      wb_valid_d     = i_Valid;
      wb_id_d        = wb_id_q;
      wb_value_d     = wb_value_q;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      frame_error_d  = frame_error_q;
      acc_d          = acc_q;
      expected_d     = expected_q;
      if (i_Valid) begin
         wb_id_d    = i_VoiceOperator;
         wb_value_d = eff;
         if (!aligned) begin
            frame_error_d = 1'b1;
         end
         if (is_last) begin
            sample_d       = sum_fmt;
            sample_valid_d = 1'b1;
            acc_d          = '0;
            expected_d     = '0;
         end else begin
            acc_d      = sum;
            expected_d = i_VoiceOperator + ID_WIDTH'(1);
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         wb_valid_q     <= 1'b0;
         wb_id_q        <= '0;
         wb_value_q     <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         frame_error_q  <= 1'b0;
         acc_q          <= '0;
         expected_q     <= '0;
      end else begin
         wb_valid_q     <= wb_valid_d;
         wb_id_q        <= wb_id_d;
         wb_value_q     <= wb_value_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         frame_error_q  <= frame_error_d;
         acc_q          <= acc_d;
         expected_q     <= expected_d;
      end
   end

   assign o_WritebackValid         = wb_valid_q;
   assign o_OperatorWritebackID    = wb_id_q;
   assign o_OperatorWritebackValue = wb_value_q;
   assign o_Sample                 = sample_q;
   assign o_SampleValid            = sample_valid_q;
   assign o_FrameError             = frame_error_q;

endmodule

// File: tb/tb_stage_operator_writeback.sv
// Directed bench for stage_operator_writeback.
module tb_stage_operator_writeback;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               i_Valid = 1'b0;
   logic               i_NoteOn = 1'b0;
   logic [6:0]         i_VoiceOperator = '0;
   logic [7:0]         i_AlgorithmWord = '0;
   logic signed [15:0] i_OperatorOutput = '0;
   logic               o_WritebackValid;
   logic [6:0]         o_OperatorWritebackID;
   logic signed [15:0] o_OperatorWritebackValue;
   logic signed [15:0] o_Sample;
   logic               o_SampleValid;
   logic               o_FrameError;

   int checks = 0;
   int errors = 0;

   // Per-slot stimulus for a frame.
   logic               car[128];
   logic signed [15:0] val[128];

   // Strobe observation across a frame.
   int                 strobe_cnt;
   logic signed [15:0] strobe_sample;
   bit                 strobe_after_last;

   always #5 clk = ~clk;

   stage_operator_writeback dut (
      .i_Clock                  (clk),
      .i_Reset_n                (rst_n),
      .i_Valid                  (i_Valid),
      .i_NoteOn                 (i_NoteOn),
      .i_VoiceOperator          (i_VoiceOperator),
      .i_AlgorithmWord          (i_AlgorithmWord),
      .i_OperatorOutput         (i_OperatorOutput),
      .o_WritebackValid         (o_WritebackValid),
      .o_OperatorWritebackID    (o_OperatorWritebackID),
      .o_OperatorWritebackValue (o_OperatorWritebackValue),
      .o_Sample                 (o_Sample),
      .o_SampleValid            (o_SampleValid),
      .o_FrameError             (o_FrameError)
   );

   // Apply one cycle of input, then settle just past the rising edge.
   task automatic drive(input logic v, input logic n, input logic [6:0] id, input logic c,
                        input logic signed [15:0] o);
      i_Valid          = v;
      i_NoteOn         = n;
      i_VoiceOperator  = id;
      i_AlgorithmWord  = {7'b1010101, c};
      i_OperatorOutput = o;
      @(posedge clk);
      #1;
   endtask

   task automatic observe(input bit after_last);
      if (o_SampleValid) begin
         strobe_cnt++;
         strobe_sample     = o_Sample;
         strobe_after_last = after_last;
      end
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 128; i++) begin
         car[i] = 1'b0;
         val[i] = 16'sd0;
      end
      strobe_cnt        = 0;
      strobe_sample     = 16'sd0;
      strobe_after_last = 1'b0;
   endtask

   task automatic run_range(input int lo, input int hi, input bit gaps);
      for (int i = lo; i <= hi; i++) begin
         drive(1'b1, 1'b1, 7'(i), car[i], val[i]);
         observe(i == 127);
         if (gaps) begin
            drive(1'b0, 1'b1, 7'd3, 1'b1, 16'sd999);
            observe(1'b0);
         end
      end
   endtask

   task automatic end_frame();
      drive(1'b0, 1'b0, 7'd0, 1'b0, 16'sd0);
      observe(1'b0);
      drive(1'b0, 1'b0, 7'd0, 1'b0, 16'sd0);
      observe(1'b0);
   endtask

   task automatic test_writeback();
      drive(1'b1, 1'b1, 7'h25, 1'b0, -16'sd1234);
      checks++;
      if (o_WritebackValid !== 1'b1) begin
         errors++;
         $display("FAIL wb_valid got %0b want 1", o_WritebackValid);
      end
      checks++;
      if (o_OperatorWritebackID !== 7'h25) begin
         errors++;
         $display("FAIL wb_id got %h want 25", o_OperatorWritebackID);
      end
      checks++;
      if (o_OperatorWritebackValue !== -16'sd1234) begin
         errors++;
         $display("FAIL wb_value got %0d want -1234", o_OperatorWritebackValue);
      end
      drive(1'b1, 1'b0, 7'h25, 1'b0, -16'sd1234);
      checks++;
      if (o_OperatorWritebackValue !== 16'sd0) begin
         errors++;
         $display("FAIL wb_value_noteoff got %0d want 0", o_OperatorWritebackValue);
      end
      drive(1'b0, 1'b1, 7'h11, 1'b1, 16'sd555);
      checks++;
      if (o_WritebackValid !== 1'b0 || o_OperatorWritebackID !== 7'h25
          || o_OperatorWritebackValue !== 16'sd0) begin
         errors++;
         $display("FAIL wb_hold got v=%0b id=%h val=%0d want v=0 id=25 val=0",
                  o_WritebackValid, o_OperatorWritebackID, o_OperatorWritebackValue);
      end
   endtask

   task automatic test_reset();
      clear_frame();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 7'(i), 1'b1, 16'sd1000);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_WritebackValid !== 1'b0 || o_OperatorWritebackID !== 7'd0
          || o_OperatorWritebackValue !== 16'sd0 || o_Sample !== 16'sd0
          || o_SampleValid !== 1'b0 || o_FrameError !== 1'b0) begin
         errors++;
         $display("FAIL reset_async got v=%0b id=%h val=%0d s=%0d sv=%0b fe=%0b want all 0",
                  o_WritebackValid, o_OperatorWritebackID, o_OperatorWritebackValue,
                  o_Sample, o_SampleValid, o_FrameError);
      end
      drive(1'b1, 1'b1, 7'd9, 1'b1, 16'sd77);
      checks++;
      if (o_WritebackValid !== 1'b0 || o_OperatorWritebackValue !== 16'sd0) begin
         errors++;
         $display("FAIL reset_hold got v=%0b val=%0d want 0 0",
                  o_WritebackValid, o_OperatorWritebackValue);
      end
      rst_n = 1'b1;
      car[0] = 1'b1;
      val[0] = 16'sd5;
      run_range(0, 127, 1'b0);
      end_frame();
      checks++;
      if (strobe_cnt != 1 || strobe_sample !== 16'sd5 || !strobe_after_last) begin
         errors++;
         $display("FAIL reset_frame got n=%0d s=%0d at_last=%0b want 1 5 1",
                  strobe_cnt, strobe_sample, strobe_after_last);
      end
      checks++;
      if (o_FrameError !== 1'b0) begin
         errors++;
         $display("FAIL reset_frame_err got %0b want 0", o_FrameError);
      end
   endtask

   task automatic setup_mix();
      clear_frame();
      for (int i = 0; i < 128; i++) begin
         val[i] = 16'sd7777;
      end
      car[0]  = 1'b1; val[0]  = 16'sd1000;
      car[8]  = 1'b1; val[8]  = 16'sd2000;
      car[16] = 1'b1; val[16] = -16'sd500;
   endtask

   task automatic test_carrier_mix();
      setup_mix();
      run_range(0, 126, 1'b0);
      checks++;
      if (strobe_cnt != 0) begin
         errors++;
         $display("FAIL mix_early_strobe got %0d want 0", strobe_cnt);
      end
      run_range(127, 127, 1'b0);
      checks++;
      if (o_SampleValid !== 1'b1 || o_Sample !== 16'sd2500) begin
         errors++;
         $display("FAIL mix_sample got sv=%0b s=%0d want 1 2500", o_SampleValid, o_Sample);
      end
      end_frame();
      checks++;
      if (o_SampleValid !== 1'b0 || strobe_cnt != 1) begin
         errors++;
         $display("FAIL mix_one_strobe got sv=%0b n=%0d want 0 1", o_SampleValid, strobe_cnt);
      end
   endtask

   task automatic test_saturation();
      logic signed [15:0] exp_s;
`ifdef STAGE_WRITEBACK_SATURATE_EN
      exp_s = 16'sd32767;
`else
      exp_s = 16'sd14464;
`endif
      clear_frame();
      for (int i = 0; i < 4; i++) begin
         car[i * 30] = 1'b1;
         val[i * 30] = 16'sd20000;
      end
      run_range(0, 127, 1'b0);
      end_frame();
      checks++;
      if (strobe_cnt != 1 || strobe_sample !== exp_s) begin
         errors++;
         $display("FAIL saturation got n=%0d s=%0d want 1 %0d", strobe_cnt, strobe_sample, exp_s);
      end
   endtask

   task automatic test_gaps();
      setup_mix();
      run_range(0, 127, 1'b1);
      end_frame();
      checks++;
      if (strobe_cnt != 1 || strobe_sample !== 16'sd2500 || !strobe_after_last) begin
         errors++;
         $display("FAIL gaps got n=%0d s=%0d at_last=%0b want 1 2500 1",
                  strobe_cnt, strobe_sample, strobe_after_last);
      end
   endtask

   task automatic test_misalign();
      clear_frame();
      for (int i = 0; i < 128; i++) begin
         car[i] = 1'b1;
         val[i] = 16'sd100;
      end
      run_range(0, 9, 1'b0);
      checks++;
      if (o_FrameError !== 1'b0) begin
         errors++;
         $display("FAIL misalign_pre got %0b want 0", o_FrameError);
      end
      run_range(20, 20, 1'b0);
      checks++;
      if (o_FrameError !== 1'b1) begin
         errors++;
         $display("FAIL misalign_flag got %0b want 1", o_FrameError);
      end
      run_range(21, 127, 1'b0);
      end_frame();
      checks++;
      if (strobe_cnt != 1 || strobe_sample !== 16'sd10800 || !strobe_after_last) begin
         errors++;
         $display("FAIL misalign_frame got n=%0d s=%0d at_last=%0b want 1 10800 1",
                  strobe_cnt, strobe_sample, strobe_after_last);
      end
      checks++;
      if (o_FrameError !== 1'b1) begin
         errors++;
         $display("FAIL misalign_sticky got %0b want 1", o_FrameError);
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 7'd0, 1'b0, 16'sd0);
      drive(1'b1, 1'b1, 7'd0, 1'b1, 16'sd300);
      checks++;
      if (o_WritebackValid !== 1'b0 || o_Sample !== 16'sd0 || o_SampleValid !== 1'b0
          || o_FrameError !== 1'b0 || o_OperatorWritebackValue !== 16'sd0) begin
         errors++;
         $display("FAIL init_reset got v=%0b s=%0d sv=%0b fe=%0b val=%0d want all 0",
                  o_WritebackValid, o_Sample, o_SampleValid, o_FrameError,
                  o_OperatorWritebackValue);
      end
      rst_n = 1'b1;
      test_writeback();
      test_reset();
      test_carrier_mix();
      test_saturation();
      test_gaps();
      test_misalign();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
